// File: rtl/rr_capture_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_capture_arb
//  Description : Round-robin arbiter with a shared capture register.
//                Each winning requester receives a grant lasting HOLD cycles.
//                On the winning edge its data slice is copied into q.
//                q_vld pulses for one cycle per capture, and q_src records
//                which requester supplied the data in q.
//  Ports       : c      - clock, rising edge
//                rst_n  - synchronous active-low reset
//                req    - request vector, bit i belongs to requester i
//                din    - requester data, requester i at [i*W +: W]
//                gnt    - registered one-hot grant (all-zero when idle)
//                q      - shared capture register
//                q_vld  - one-cycle pulse following each capture
//                q_src  - index of the requester whose data is in q
//                busy   - high while a grant tenure is active
//  Revision    : 1.0  initial release
// ============================================================================
module rr_capture_arb #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int HOLD = 2
) (
    input  logic                 c,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       din,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic                 q_vld,
    output logic [$clog2(N)-1:0] q_src,
    output logic                 busy
);

    localparam int SW = $clog2(N);
    localparam int CW = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // The initial values match the reset values, so the block powers up in
    // its reset state.
    state_t         state_q = IDLE;
    state_t         state_d;
    logic [CW-1:0]  cnt_q   = '0;
    logic [CW-1:0]  cnt_d;
    logic [SW-1:0]  last_q  = SW'(N-1);
    logic [SW-1:0]  last_d;
    logic [N-1:0]   gnt_q   = '0;
    logic [N-1:0]   gnt_d;
    logic [W-1:0]   data_q  = '0;
    logic [W-1:0]   data_d;
    logic [SW-1:0]  src_q   = '0;
    logic [SW-1:0]  src_d;
    logic           vld_q   = 1'b0;
    logic           vld_d;

    logic           arb_en;
    logic           found;
    logic [SW-1:0]  win;
    int             idx;

    // Arbitration is allowed while idle, or on the final cycle of a tenure.
    assign arb_en = (state_q == IDLE) || (cnt_q == '0);

    // Round-robin search. It starts just after the last winner and wraps.
    // The previous owner is examined last, so it is selected again only
    // when no other requester is asserting req.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        src_d   = src_q;
        vld_d   = 1'b0;
        if (arb_en) begin
            if (found) begin
                state_d = OWN;
                cnt_d   = CW'(HOLD - 1);
                last_d  = win;
                gnt_d   = N'(1) << win;
                data_d  = din[int'(win)*W +: W];
                src_d   = win;
                vld_d   = 1'b1;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
            end
        end else begin
            // A tenure in progress ignores req, including a drop by the owner.
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge c) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= SW'(N-1);
            gnt_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            src_q   <= src_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt   = gnt_q;
    assign q     = data_q;
    assign q_vld = vld_q;
    assign q_src = src_q;
    assign busy  = (state_q == OWN);

endmodule
`default_nettype wire

// File: tb/tb_rr_capture_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_capture_arb
//  Description : Self-checking bench for rr_capture_arb. It drives one
//                instance with HOLD=2 and one with HOLD=1 from the same
//                inputs. A tenure-level reference model predicts the
//                outputs of each instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_capture_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           c = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;

    logic [N-1:0]   gnt2, gnt1;
    logic [W-1:0]   q2, q1;
    logic           vld2, vld1, busy2, busy1;
    logic [1:0]     src2, src1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 c = ~c;

    rr_capture_arb #(.N(N), .W(W), .HOLD(2)) u_h2 (
        .c(c), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt2), .q(q2), .q_vld(vld2), .q_src(src2), .busy(busy2)
    );

    rr_capture_arb #(.N(N), .W(W), .HOLD(1)) u_h1 (
        .c(c), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt1), .q(q1), .q_vld(vld1), .q_src(src1), .busy(busy1)
    );

    // Reference model, one entry per instance (0: HOLD=2, 1: HOLD=1).
    // owner is -1 when idle. left counts the tenure cycles still to run,
    // including the current one.
    int         m_owner[2];
    int         m_left[2];
    int         m_last[2];
    logic [7:0] m_q[2];
    int         m_src[2];
    logic       m_vld[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset(int i);
        m_owner[i] = -1;
        m_left[i]  = 0;
        m_last[i]  = N - 1;
        m_q[i]     = '0;
        m_src[i]   = 0;
        m_vld[i]   = 1'b0;
    endfunction

    function automatic void model_edge(int i, int hold);
        int w;
        logic [N*W-1:0] d;
        d = din;
        if (!rst_n) begin
            model_reset(i);
        end else if (m_owner[i] < 0 || m_left[i] == 1) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && req[(m_last[i] + k) % N]) w = (m_last[i] + k) % N;
            if (w >= 0) begin
                m_owner[i] = w;
                m_left[i]  = hold;
                m_last[i]  = w;
                m_q[i]     = d[w*W +: W];
                m_src[i]   = w;
                m_vld[i]   = 1'b1;
            end else begin
                m_owner[i] = -1;
                m_left[i]  = 0;
                m_vld[i]   = 1'b0;
            end
        end else begin
            m_left[i] = m_left[i] - 1;
            m_vld[i]  = 1'b0;
        end
    endfunction

    function automatic logic [N-1:0] exp_gnt(int i);
        return (m_owner[i] < 0) ? '0 : (N'(1) << m_owner[i]);
    endfunction

    // Advance one clock. The model steps on the edge using the inputs
    // already applied, and the outputs are compared 1 time unit later.
    task automatic cyc();
        @(posedge c);
        model_edge(0, 2);
        model_edge(1, 1);
        #1;
        check("h2_gnt",  32'(gnt2),  32'(exp_gnt(0)));
        check("h2_q",    32'(q2),    32'(m_q[0]));
        check("h2_src",  32'(src2),  32'(m_src[0]));
        check("h2_vld",  32'(vld2),  32'(m_vld[0]));
        check("h2_busy", 32'(busy2), 32'(m_owner[0] >= 0));
        check("h2_onehot_busy", 32'(($countones(gnt2) <= 1) && (busy2 == (gnt2 != '0))), 32'd1);
        check("h1_gnt",  32'(gnt1),  32'(exp_gnt(1)));
        check("h1_q",    32'(q1),    32'(m_q[1]));
        check("h1_src",  32'(src1),  32'(m_src[1]));
        check("h1_vld",  32'(vld1),  32'(m_vld[1]));
        check("h1_busy", 32'(busy1), 32'(m_owner[1] >= 0));
        check("h1_onehot_busy", 32'(($countones(gnt1) <= 1) && (busy1 == (gnt1 != '0))), 32'd1);
    endtask

    task automatic set_din_inc(input logic [7:0] base);
        for (int i = 0; i < N; i++) din[i*W +: W] = base + 8'(i);
    endtask

    logic [7:0] seq_q[$];
    logic [7:0] exp_seq[5];
    logic [1:0] src_seq[$];

    initial begin
        model_reset(0);
        model_reset(1);
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        #2;
        cyc();
        cyc();
        check("reset_gnt", 32'(gnt2), 32'd0);
        check("reset_q",   32'(q2),   32'd0);

        // Single request, with A5 on requester 0.
        rst_n = 1'b1;
        req   = 4'b0001;
        din   = '0;
        din[7:0] = 8'hA5;
        cyc();
        check("single_q",   32'(q2),   32'hA5);
        check("single_gnt", 32'(gnt2), 32'b0001);
        check("single_vld", 32'(vld2), 32'd1);
        req = '0;
        cyc();
        check("single_hold", 32'(gnt2), 32'b0001);
        cyc();
        cyc();
        check("single_idle", 32'(busy2), 32'd0);

        // Fairness: all requesting, data 0x10+i. Record HOLD=2 captures.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req   = 4'b1111;
        set_din_inc(8'h10);
        seq_q.delete();
        for (int t = 0; t < 10; t++) begin
            cyc();
            if (vld2) seq_q.push_back(q2);
        end
        exp_seq[0] = 8'h10; exp_seq[1] = 8'h11; exp_seq[2] = 8'h12;
        exp_seq[3] = 8'h13; exp_seq[4] = 8'h10;
        check("rr_count", 32'(seq_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < seq_q.size(); i++)
            check("rr_seq", 32'(seq_q[i]), 32'(exp_seq[i]));

        // Wrap and skip: make 2 the last winner, then request 0 and 1.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req   = 4'b0100;
        cyc();
        req = 4'b0011;
        src_seq.delete();
        for (int t = 0; t < 7; t++) begin
            cyc();
            if (vld2) src_seq.push_back(src2);
        end
        check("wrap_count", 32'(src_seq.size()), 32'd3);
        if (src_seq.size() >= 3) begin
            check("wrap_w0", 32'(src_seq[0]), 32'd0);
            check("wrap_w1", 32'(src_seq[1]), 32'd1);
            check("wrap_w2", 32'(src_seq[2]), 32'd0);
        end

        // Early drop: requester 1 wins and then drops req.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req   = 4'b0010;
        set_din_inc(8'h40);
        cyc();
        req = 4'b0000;
        cyc();
        check("drop_gnt", 32'(gnt2), 32'b0010);
        check("drop_q",   32'(q2),   32'h41);
        cyc();
        check("drop_end", 32'(gnt2), 32'd0);
        check("drop_qkeep", 32'(q2), 32'h41);

        // Reset mid-tenure while requester 2 owns the grant.
        req = 4'b0100;
        cyc();
        rst_n = 1'b0;
        cyc();
        check("rst_gnt", 32'(gnt2), 32'd0);
        check("rst_q",   32'(q2),   32'd0);
        check("rst_vld", 32'(vld2), 32'd0);
        rst_n = 1'b1;
        req   = 4'b1111;
        cyc();
        check("rst_first", 32'(gnt2), 32'b0001);

        // HOLD=1 back-to-back with 0 and 2 requesting.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req   = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            cyc();
            check("h1_b2b_src", 32'(src1), 32'((t % 2) * 2));
            check("h1_b2b_vld", 32'(vld1), 32'd1);
        end

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 600; t++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            req   = N'($urandom);
            for (int i = 0; i < N; i++) din[i*W +: W] = 8'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_capture_arb.md
RR_CAPTURE_ARB -- requirements
Module: rr_capture_arb

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter W, default 8: data width of each requester and of the shared capture register.
REQ-003 Parameter HOLD, default 2: grant tenure in clock cycles; legal range 1..15.
REQ-004 c  in  1  clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req  in  N  request vector; bit i is requester i.
REQ-007 din  in  N*W  requester data; requester i occupies bits [i*W +: W].
REQ-008 gnt  out  N  registered one-hot grant, or all-zero.
REQ-009 q  out  W  shared capture register.
REQ-010 q_vld  out  1  one-cycle pulse, high in the cycle after q was loaded.
REQ-011 q_src  out  clog2(N)  index of the requester whose data is in q.
REQ-012 busy  out  1  high while a grant tenure is active.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE (no owner) and OWN (grant active, tenure counter running).
REQ-014 Arbitration SHALL occur only in IDLE, or in OWN on the last tenure cycle (tenure counter = 0).
REQ-015 Winner selection SHALL be round-robin: the lowest index strictly after the last winner, wrapping from N-1 to 0, among the set req bits.
REQ-016 On an arbitration edge with any req bit set, the block SHALL register all of the following on that same edge:
  - q <= din slice of the winner
  - q_src <= winner index
  - gnt <= one-hot of the winner
  - q_vld <= 1
  - counter <= HOLD-1
  - next state = OWN
REQ-017 Latency: req sampled high at edge k SHALL give gnt, q, q_src and q_vld visible after edge k (one cycle); no combinational path from req or din to any output.
REQ-018 A grant SHALL last exactly HOLD cycles. The counter decrements each OWN cycle and the tenure ends on the edge where the counter equals 0.
REQ-019 At tenure end, if any req bit is set, a new grant SHALL be issued on the same edge with no bubble cycle. Otherwise gnt SHALL clear and the FSM SHALL return to IDLE.
REQ-020 The current owner SHALL be eligible again at tenure end only if no other requester is asserting req.
REQ-021 A requester dropping req during its own tenure SHALL NOT shorten the tenure; gnt stays high until the counter expires.
REQ-022 req changes during OWN, other than on the final tenure cycle, SHALL be ignored.
REQ-023 q and q_src SHALL hold their values between captures; only an arbitration win reloads them.
REQ-024 q_vld SHALL be high for exactly one cycle per capture, including back-to-back captures (a HOLD=1 stream gives q_vld high continuously).
REQ-025 busy SHALL equal (state == OWN) and SHALL be high exactly when gnt is non-zero.
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 While rst_n is 0 at a rising edge of c, the block SHALL set all of the following:
  - state = IDLE
  - gnt = 0, q = 0, q_src = 0, q_vld = 0, busy = 0
  - counter = 0
  - last-winner pointer = N-1, so requester 0 has top priority
REQ-028 Reset asserted mid-tenure SHALL abort the tenure on that edge with no capture. The first arbitration after release SHALL happen at the first edge with rst_n = 1.
REQ-029 Before the first clock edge, power-up register values SHALL equal the reset values.

Verification (N=4, W=8, HOLD=2)
REQ-030 Single request: req=0001, din[0]=0xA5 from cycle 0 -> after edge 0: gnt=0001, q=0xA5, q_src=0, q_vld=1; gnt stays 0001 for 2 cycles; req=0 afterwards -> gnt=0, busy=0.
REQ-031 Round-robin fairness: req=1111 held, din[i]=0x10+i -> q sequence 0x10, 0x11, 0x12, 0x13, 0x10, each tenure 2 cycles, no gap, q_vld pulses every 2 cycles.
REQ-032 Wrap and skip: last winner 2, req=0011 -> next winner 0, then 1, then 0.
REQ-033 Early drop: winner 1 drops req one cycle into its tenure -> gnt=0010 held for the full 2 cycles; q unchanged until the next win.
REQ-034 Reset mid-tenure: rst_n=0 for one edge during gnt=0100 -> gnt=0, q=0, q_vld=0; with req=1111 after release, the first winner is 0.
REQ-035 HOLD=1 back-to-back: req=0101 held -> winners 0, 2, 0, 2 on consecutive cycles; q_vld constantly 1; gnt always one-hot.
